// File: rtl/menu_pkg.sv
// Shared definitions for the game menu controller and the renderer:
// screen codes, state enum and default timing constants.
package menu_pkg;

   localparam logic [2:0] ST_MENU1P = 3'b000;
   localparam logic [2:0] ST_MENU2P = 3'b001;
   localparam logic [2:0] ST_CD3    = 3'b010;
   localparam logic [2:0] ST_CD2    = 3'b011;
   localparam logic [2:0] ST_CD1    = 3'b100;
   localparam logic [2:0] ST_START  = 3'b101;
   localparam logic [2:0] ST_PLAY   = 3'b110;
   localparam logic [2:0] ST_OVER   = 3'b111;

   localparam int STEP_CYCLES_DEF  = 25_000_000;
   localparam int START_CYCLES_DEF = 12_500_000;

   typedef enum logic [2:0] {
      S_MENU1P = ST_MENU1P,
      S_MENU2P = ST_MENU2P,
      S_CD3    = ST_CD3,
      S_CD2    = ST_CD2,
      S_CD1    = ST_CD1,
      S_START  = ST_START,
      S_PLAY   = ST_PLAY,
      S_OVER   = ST_OVER
   } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a conditioned button level. The history register
// resets high so a button held through reset does not fire on release.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= btn;
   end

   assign rise = btn & ~prev_q;

endmodule

// File: rtl/game_menu_fsm.sv
// Game-flow controller: menu select, timed 3-2-1 countdown, START banner,
// gameplay hand-off and latched round result for the game-over screen.
//
// state  | meaning
// MENU1P | menu, 1-player highlighted
// MENU2P | menu, 2-player highlighted
// CD3    | countdown "3", STEP_CYCLES long
// CD2    | countdown "2", STEP_CYCLES long
// CD1    | countdown "1", STEP_CYCLES long
// START  | START banner, START_CYCLES long
// PLAY   | gameplay running, waiting for game_over
// OVER   | result screen, waiting for select
module game_menu_fsm
   import menu_pkg::*;
#(
   parameter int STEP_CYCLES  = STEP_CYCLES_DEF,
   parameter int START_CYCLES = START_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_select,
   input  logic       game_over,
   input  logic       p1_alive,
   input  logic       p2_alive,
   output logic [2:0] state,
   output logic       P1win,
   output logic       P2win,
   output logic       draw,
   output logic       mode_2p,
   output logic       game_active
);

   localparam int MAX_CYCLES = (STEP_CYCLES > START_CYCLES) ? STEP_CYCLES : START_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

   logic up_rise, down_rise, sel_rise;

   btn_edge u_up   (.clk(clk), .rst(rst), .btn(btn_up),     .rise(up_rise));
   btn_edge u_down (.clk(clk), .rst(rst), .btn(btn_down),   .rise(down_rise));
   btn_edge u_sel  (.clk(clk), .rst(rst), .btn(btn_select), .rise(sel_rise));

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             p1win_q, p1win_d, p2win_q, p2win_d, draw_q, draw_d;
   logic             mode_q, mode_d;
   logic             timed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_MENU1P;
         cnt_q   <= '0;
         p1win_q <= 1'b0;
         p2win_q <= 1'b0;
         draw_q  <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p1win_q <= p1win_d;
         p2win_q <= p2win_d;
         draw_q  <= draw_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p1win_d = p1win_q;
      p2win_d = p2win_q;
      draw_d  = draw_q;
      mode_d  = mode_q;
      timed   = 1'b0;
      case (state_q)
         S_MENU1P: begin
            // select has priority over a simultaneous up/down edge
            if (sel_rise) begin
               mode_d  = 1'b0;
               state_d = S_CD3;
            end else if (up_rise ^ down_rise) begin
               state_d = S_MENU2P;
            end
         end
         S_MENU2P: begin
            if (sel_rise) begin
               mode_d  = 1'b1;
               state_d = S_CD3;
            end else if (up_rise ^ down_rise) begin
               state_d = S_MENU1P;
            end
         end
         S_CD3: begin
            timed = 1'b1;
            if (cnt_q == STEP_LAST) state_d = S_CD2;
         end
         S_CD2: begin
            timed = 1'b1;
            if (cnt_q == STEP_LAST) state_d = S_CD1;
         end
         S_CD1: begin
            timed = 1'b1;
            if (cnt_q == STEP_LAST) state_d = S_START;
         end
         S_START: begin
            timed = 1'b1;
            if (cnt_q == START_LAST) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (game_over) begin
               state_d = S_OVER;
               p1win_d = p1_alive & ~p2_alive;
               p2win_d = ~p1_alive & p2_alive;
               draw_d  = ~(p1_alive ^ p2_alive);
            end
         end
         S_OVER: begin
            if (sel_rise) begin
               state_d = S_MENU1P;
               p1win_d = 1'b0;
               p2win_d = 1'b0;
               draw_d  = 1'b0;
            end
         end
         default: state_d = S_MENU1P;
      endcase
   end

   // Counter restarts from zero on every state entry, so it can never wrap.
   assign cnt_d = (timed && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;

   assign state       = state_q;
   assign P1win       = p1win_q;
   assign P2win       = p2win_q;
   assign draw        = draw_q;
   assign mode_2p     = mode_q;
   assign game_active = (state_q == S_PLAY);

endmodule

// File: tb/tb_game_menu_fsm.sv
// Directed bench for game_menu_fsm with short countdown timing
// (4 cycles per digit, 3 cycles of START banner).
module tb_game_menu_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_down, btn_select, game_over, p1_alive, p2_alive;
   logic [2:0] state;
   logic       P1win, P2win, draw, mode_2p, game_active;

   int n_cmp = 0;
   int n_bad = 0;

   game_menu_fsm #(.STEP_CYCLES(4), .START_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select),
      .game_over(game_over), .p1_alive(p1_alive), .p2_alive(p2_alive),
      .state(state), .P1win(P1win), .P2win(P2win), .draw(draw),
      .mode_2p(mode_2p), .game_active(game_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       up, dn, sel, go, p1, p2;
      logic [2:0] st;
      logic       w1, w2, dr, m, act;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic up, logic dn, logic sel, logic go, logic p1, logic p2,
                               logic [2:0] st, logic w1, logic w2, logic dr, logic m, logic act);
      vec_t v;
      v.up = up; v.dn = dn; v.sel = sel; v.go = go; v.p1 = p1; v.p2 = p2;
      v.st = st; v.w1 = w1; v.w2 = w2; v.dr = dr; v.m = m; v.act = act;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] st, input logic w1,
                            input logic w2, input logic dr, input logic m, input logic act);
      check({name, ".state"},  {5'd0, state}, {5'd0, st});
      check({name, ".flags"},  {3'd0, P1win, P2win, draw, mode_2p, game_active},
                               {3'd0, w1, w2, dr, m, act});
   endtask

   task automatic drive(input logic up, input logic dn, input logic sel,
                        input logic go, input logic p1, input logic p2);
      @(negedge clk);
      btn_up = up; btn_down = dn; btn_select = sel;
      game_over = go; p1_alive = p1; p2_alive = p2;
      @(posedge clk); #1;
   endtask

   // select pulse from MENU1P, then measure edges until PLAY is reached
   task automatic run_to_play(input string name);
      int n;
      drive(0, 0, 1, 0, 0, 0);
      check({name, ".cd3"}, {5'd0, state}, 8'h02);
      drive(0, 0, 0, 0, 0, 0);
      n = 1;
      while (state != 3'b110 && n < 40) begin
         drive(0, 0, 0, 0, 0, 0);
         n++;
      end
      check({name, ".edges_to_play"}, 8'(n), 8'd15);
   endtask

   initial begin
      rst = 1'b1;
      btn_up = 0; btn_down = 0; btn_select = 1; game_over = 0; p1_alive = 0; p2_alive = 0;
      repeat (3) @(posedge clk);
      #1 check_all("reset", 3'b000, 0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;

      //            up dn sel go p1 p2  st     w1 w2 dr m  act
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0)); // held through reset
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0)); // both cancel
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b010, 0, 0, 0, 1, 0)); // select beats up
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 0)); // ignored
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3'b010, 0, 0, 0, 1, 0)); // ignored
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0, 1, 0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3'b101, 0, 0, 0, 1, 0)); // ignored
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b101, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b101, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b110, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b110, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3'b111, 1, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3'b111, 1, 0, 0, 1, 0)); // held
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'b111, 1, 0, 0, 1, 0)); // up ignored
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3'b000, 0, 0, 0, 1, 0)); // game_over ignored
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].up, vecs[i].dn, vecs[i].sel, vecs[i].go, vecs[i].p1, vecs[i].p2);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].w1, vecs[i].w2,
                   vecs[i].dr, vecs[i].m, vecs[i].act);
      end

      // 1-player round ending with both alive, then P2 win, then both dead
      run_to_play("rnd_a");
      drive(0, 0, 0, 1, 1, 1);
      check_all("draw_alive", 3'b111, 0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      check_all("over_exit_a", 3'b000, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      run_to_play("rnd_b");
      drive(0, 0, 0, 1, 0, 1);
      check_all("p2_win", 3'b111, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      run_to_play("rnd_c");
      drive(0, 0, 0, 1, 0, 0);
      check_all("draw_dead", 3'b111, 0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      check_all("over_exit_c", 3'b000, 0, 0, 0, 0, 0);

      // async reset in CD2 with select held; restart needs a fresh select edge
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      check_all("restart_cd3", 3'b010, 0, 0, 0, 1, 0);
      repeat (5) drive(0, 0, 1, 0, 0, 0);
      check_all("in_cd2", 3'b011, 0, 0, 0, 1, 0);
      @(negedge clk); #2 rst = 1'b1;
      #1 check_all("async_rst", 3'b000, 0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;
      drive(0, 0, 1, 0, 0, 0);
      check_all("post_rst_held", 3'b000, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      check_all("post_rst_idle", 3'b000, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      check_all("post_rst_sel", 3'b010, 0, 0, 0, 0, 0);

      // reset mid-PLAY discards a game_over arriving with it
      drive(0, 0, 0, 0, 0, 0);
      repeat (14) drive(0, 0, 0, 0, 0, 0);
      check_all("play_again", 3'b110, 0, 0, 0, 0, 1);
      @(negedge clk);
      game_over = 1; p1_alive = 1; p2_alive = 0; rst = 1'b1;
      @(posedge clk); #1;
      check_all("rst_in_play", 3'b000, 0, 0, 0, 0, 0);
      @(negedge clk) begin rst = 1'b0; game_over = 0; end
      @(posedge clk); #1;
      check_all("rst_in_play_rel", 3'b000, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/game_menu_fsm.md
# game_menu_fsm

Game-flow controller that generates the screen-select code and result flags consumed by the menu/overlay renderer. It decodes player button presses, steps through mode selection, a timed 3-2-1 countdown and the "START" banner, hands control to gameplay, and latches the round result for the game-over screen. It runs on the 25 MHz pixel clock alongside the VGA path; its outputs feed the renderer's `state`, `P1win`, `P2win` and `draw` inputs directly.

## Interface
- `STEP_CYCLES`, default 25_000_000: clock cycles per countdown digit (1 s at 25 MHz).
- `START_CYCLES`, default 12_500_000: clock cycles the START banner is shown.
- `clk` in 1: 25 MHz pixel clock; single clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `btn_up` in 1: level, active-high, already debounced and synchronous to `clk`.
- `btn_down` in 1: level, active-high, same conditioning.
- `btn_select` in 1: level, active-high, same conditioning.
- `game_over` in 1: one-cycle pulse from game logic when the round ends.
- `p1_alive` in 1: player 1 alive flag, sampled on `game_over`.
- `p2_alive` in 1: player 2 alive flag, sampled on `game_over`.
- `state` out 3: screen code to the renderer.
- `P1win` out 1: player 1 won; valid in OVER.
- `P2win` out 1: player 2 won; valid in OVER.
- `draw` out 1: tie; valid in OVER.
- `mode_2p` out 1: selected mode, 0 = 1-player, 1 = 2-player; held from select until the next select in the menu.
- `game_active` out 1: high only in PLAY.

## Operation
- States and codes: MENU1P 000, MENU2P 001, CD3 010, CD2 011, CD1 100, START 101, PLAY 110, OVER 111.
- Buttons act on their rising edge only: the button level is high and the previous-cycle register is low.
  - The previous-cycle registers reset to 1, so a button held through reset does not fire.
- MENU1P and MENU2P:
  - An up or down edge toggles between the two states.
  - Up and down edges in the same cycle cause no change.
  - A select edge loads `mode_2p` (0 from MENU1P, 1 from MENU2P) and goes to CD3.
  - If select and up/down edges occur in the same cycle, select wins.
- Countdown sequence: CD3 → CD2 → CD1 → START, each state held exactly `STEP_CYCLES` cycles.
- START is held `START_CYCLES` cycles, then goes to PLAY.
- Buttons are ignored in all countdown states and in START.
- PLAY:
  - `game_over` high → OVER. In the same edge, latch the result:
    - `p1_alive & ~p2_alive` → P1win=1.
    - `~p1_alive & p2_alive` → P2win=1.
    - Otherwise → draw=1.
  - Exactly one result flag is high in OVER.
- OVER: a select edge → MENU1P and clears all result flags. Up/down are ignored.
- `game_over` outside PLAY is ignored.

## Timing
- All outputs are registered or decoded from registers; there is no combinational path from any input to any output.
- Reset values:
  - `state` = 000.
  - `P1win`, `P2win`, `draw`, `mode_2p`, `game_active` = 0.
  - Cycle counter = 0.
- Button latency: an edge sampled at clock edge N is visible on `state` after edge N.
- The cycle counter clears on every state entry. A timed state exits at the edge where counter == limit-1, which makes the dwell exactly limit cycles.
- Counter width is `$clog2(max(STEP_CYCLES, START_CYCLES))`. No wrap is possible because the counter clears on exit.
- Result flags update on the same edge that enters OVER and hold until the edge that leaves OVER.
- `rst` asserted mid-countdown or mid-PLAY returns everything to reset values immediately. The pending `game_over` result is discarded.

## Structure
- Shared package `menu_pkg` holds:
  - The eight 3-bit state code localparams, shared with the renderer so the screen codes match.
  - The default timing constants.
- Sub-module `btn_edge`: a previous-value register plus rising-edge output, with the async reset value 1. It is instantiated three times.

## Test plan
Bench parameters: `STEP_CYCLES`=4, `START_CYCLES`=3.
- Hold `btn_select` high during reset, then release reset → `state` stays 000 and no transition occurs.
- From 000, pulse down → 001; pulse up → 000; pulse up and down together → stays 000.
- From 001, pulse select:
  - `mode_2p`=1 and state 010 on the next edge.
  - 010, 011 and 100 each last 4 cycles, then 101 lasts 3 cycles, then 110 with `game_active`=1.
- In 110, pulse `game_over` with `p1_alive`=1, `p2_alive`=0 → 111 with P1win=1, P2win=0, draw=0.
  - A repeat with both alive gives draw=1. A repeat with both dead gives draw=1.
- In 111, pulse select → 000 and all flags 0. A `game_over` pulse while in 000 → no change.
- Assert `rst` during 011 → all outputs at reset values asynchronously. After release, a select edge is required to restart.
